bus_xfer_seq: RTL and testbench
===============================

BUS_XFER_SEQ -- requirements
Module: bus_xfer_seq

Interface
REQ-001 Parameter NREG, default 8: number of bus registers addressed; legal range 2..8.
REQ-002 Parameter W, default 12: bus word width; used only for the debug capture port.
REQ-003 SYSCLK  input  1  single system clock; all state changes on rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  transfer request present.
REQ-006 req_ready  output  1  sequencer accepts the request this cycle.
REQ-007 req_src  input  3  source register index.
REQ-008 req_dst  input  NREG  destination mask, one bit per register; broadcast allowed.
REQ-009 oe  output  NREG  one-hot bus output enables to the register file.
REQ-010 hold  output  1  shared sample control; 0 = registers sample the bus at the next edge.
REQ-011 latch  output  NREG  per-register commit strobes.
REQ-012 done  output  1  one-cycle pulse: transfer commits at the end of this cycle.
REQ-013 err  output  1  one-cycle pulse: src >= NREG or dst mask is zero.
REQ-014 bus  input  W  shared bus; captured for debug only.
REQ-015 last_word  output  W  bus value sampled during the most recent DRIVE stage.

Function
REQ-016 Handshake: a request is accepted on an edge where req_valid and req_ready are both 1; src and dst are registered at that edge.
REQ-017 Two stages: DRIVE in the cycle after acceptance, then LATCH in the following cycle; each stage is a valid bit plus its operands.
REQ-018 During DRIVE: oe[src]=1, hold=0, last_word <= bus at the end of the cycle.
REQ-019 During LATCH: latch = dst mask, done=1, oe bit of that transfer = 0.
REQ-020 hold=0 if and only if a DRIVE stage is valid; otherwise hold=1.
REQ-021 At most one oe bit is ever high; oe=0 whenever no DRIVE stage is valid.
REQ-022 src >= NREG: the request is accepted, oe stays 0 in DRIVE, and err pulses in DRIVE; LATCH still occurs.
REQ-023 Zero dst mask: the request is accepted and DRIVE occurs; LATCH asserts no latch bits, with done=1 and err=1 in that cycle.
REQ-024 src bit set in dst is legal: the register reloads its own value.
REQ-025 All outputs are registered or decoded directly from stage registers; no combinational path from req_* to oe, hold, or latch.
REQ-026 req_ready depends only on stage state, never on req_valid.

Reset
REQ-027 RESET_N low clears both stage valids immediately, without waiting for a clock edge.
REQ-028 Reset values: oe=0, latch=0, hold=1, done=0, err=0, req_ready=0, last_word=0.
REQ-029 req_ready rises in the first cycle after RESET_N deasserts, following the first rising edge.
REQ-030 A transfer in flight at reset is discarded; no latch strobe is emitted for it.

Configuration
REQ-031 Macro XFER_PIPE_EN defined: req_ready = !DRIVE valid || LATCH slot free next cycle, which in practice is always 1 after reset.
REQ-032 With XFER_PIPE_EN, back-to-back requests overlap: DRIVE of transfer N+1 coincides with LATCH of transfer N, giving one transfer per cycle. This is legal because registers commit the old sampled word while sampling the new bus word on the same edge.
REQ-033 Without XFER_PIPE_EN: req_ready = !DRIVE valid && !LATCH valid, giving one transfer per 3 cycles; DRIVE and LATCH never overlap.

Structure
REQ-034 Shared package pdp8_bus_pkg holds the constants BUS_W=12 and NREG_MAX=8 and the error-cause encoding.
REQ-035 Sub-module bus_xfer_dec: registered-free 3-to-NREG one-hot decoder with an in-range flag, instantiated once for oe.
REQ-036 Target size is 120-400 lines of RTL.

Verification
REQ-037 Reset: hold RESET_N=0 mid-transfer with latch=0x04 pending -> outputs take reset values within the same cycle; no latch pulse after release.
REQ-038 Single transfer src=2, dst=0x08, bus driven 0xABC when oe[2]=1 -> DRIVE cycle: oe=0x04, hold=0. Next cycle: latch=0x08, done=1. last_word=0xABC.
REQ-039 With XFER_PIPE_EN, three back-to-back requests (1->0x01, 3->0x02, 5->0x04) -> done pulses on three consecutive cycles; oe and latch overlap as in REQ-032; hold=0 for three cycles.
REQ-040 Without XFER_PIPE_EN, same three requests -> req_ready low for 2 of every 3 cycles; done spaced 3 cycles apart.
REQ-041 Error cases: src=7 with NREG=6 -> oe=0 and err pulses in DRIVE, then done. dst=0 -> latch=0 with done=1 and err=1.
REQ-042 Broadcast src=1, dst=0xFF -> a single LATCH cycle with latch=0xFF; oe=0x02 in the prior cycle only.

Source files
------------

// File: rtl/pdp8_bus_pkg.sv
// Shared constants and error-cause encoding for the PDP-8 style register bus.
package pdp8_bus_pkg;

  localparam int BUS_W    = 12;
  localparam int NREG_MAX = 8;
  localparam int SRC_W    = 3;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_SRC_RANGE = 2'd1,
    ERR_DST_ZERO  = 2'd2
  } errCause_e;

endpackage

// File: rtl/bus_xfer_dec.sv
// Purely combinational source-index to one-hot output-enable decoder with a
// range flag; an out-of-range index yields an all-zero enable vector.
import pdp8_bus_pkg::*;

module bus_xfer_dec #(
  parameter int NREG = NREG_MAX
) (
  input  logic [SRC_W-1:0] idx_i,
  input  logic             en_i,
  output logic [NREG-1:0]  onehot_o,
  output logic             inRange_o
);

  always_comb begin
    onehot_o  = '0;
    inRange_o = (int'(idx_i) < NREG);
    for (int i = 0; i < NREG; i++) begin
      onehot_o[i] = en_i && (int'(idx_i) == i);
    end
  end

endmodule

// File: rtl/bus_xfer_seq.sv
// Two-stage (DRIVE, LATCH) register-to-register bus transfer sequencer.
// Define XFER_PIPE_EN to overlap DRIVE of one transfer with LATCH of the previous.
import pdp8_bus_pkg::*;

module bus_xfer_seq #(
  parameter int NREG = NREG_MAX,
  parameter int W    = BUS_W
) (
  input  logic             SYSCLK,
  input  logic             RESET_N,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SRC_W-1:0] req_src,
  input  logic [NREG-1:0]  req_dst,
  output logic [NREG-1:0]  oe,
  output logic             hold,
  output logic [NREG-1:0]  latch,
  output logic             done,
  output logic             err,
  input  logic [W-1:0]     bus,
  output logic [W-1:0]     last_word
);

  logic             drvValid_q, drvValid_d;
  logic [SRC_W-1:0] drvSrc_q, drvSrc_d;
  logic [NREG-1:0]  drvDst_q, drvDst_d;
  logic             latValid_q, latValid_d;
  logic [NREG-1:0]  latDst_q, latDst_d;
  logic             rdyEn_q;
  logic [W-1:0]     lastWord_q, lastWord_d;
  logic             accept;
  logic             srcInRange;
  errCause_e        drvCause, latCause;

  // rdyEn_q holds off acceptance until the first edge after reset release.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      drvValid_q <= 1'b0;
      drvSrc_q   <= '0;
      drvDst_q   <= '0;
      latValid_q <= 1'b0;
      latDst_q   <= '0;
      rdyEn_q    <= 1'b0;
      lastWord_q <= '0;
    end else begin
      drvValid_q <= drvValid_d;
      drvSrc_q   <= drvSrc_d;
      drvDst_q   <= drvDst_d;
      latValid_q <= latValid_d;
      latDst_q   <= latDst_d;
      rdyEn_q    <= 1'b1;
      lastWord_q <= lastWord_d;
    end
  end

  assign accept = req_valid && req_ready;

  always_comb begin
    drvValid_d = accept;
    drvSrc_d   = drvSrc_q;
    drvDst_d   = drvDst_q;
    latValid_d = drvValid_q;
    latDst_d   = latDst_q;
    lastWord_d = lastWord_q;
    if (accept) begin
      drvSrc_d = req_src;
      drvDst_d = req_dst;
    end
    if (drvValid_q) begin
      latDst_d   = drvDst_q;
      lastWord_d = bus;
    end
  end

`ifdef XFER_PIPE_EN
  // LATCH always drains in one cycle, so its slot is free for the next DRIVE.
  assign req_ready = rdyEn_q;
`else
  assign req_ready = rdyEn_q && !drvValid_q && !latValid_q;
`endif

  bus_xfer_dec #(.NREG(NREG)) u_dec (
    .idx_i     (drvSrc_q),
    .en_i      (drvValid_q),
    .onehot_o  (oe),
    .inRange_o (srcInRange)
  );

  always_comb begin
    drvCause = ERR_NONE;
    latCause = ERR_NONE;
    if (drvValid_q && !srcInRange) drvCause = ERR_SRC_RANGE;
    if (latValid_q && (latDst_q == '0)) latCause = ERR_DST_ZERO;
  end

  assign err       = (drvCause != ERR_NONE) || (latCause != ERR_NONE);
  assign hold      = !drvValid_q;
  assign latch     = latValid_q ? latDst_q : '0;
  assign done      = latValid_q;
  assign last_word = lastWord_q;

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Directed bench for bus_xfer_seq: vector table for single transfers plus
// hand sequences for reset-in-flight, back-to-back and out-of-range source.
import pdp8_bus_pkg::*;

module tb_bus_xfer_seq;

`ifdef XFER_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic        SYSCLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        req_valid, req_ready, hold, done, err;
  logic [2:0]  req_src;
  logic [7:0]  req_dst, oe, latch;
  logic [11:0] bus, last_word;

  logic        r6Valid, r6Ready, r6Hold, r6Done, r6Err;
  logic [2:0]  r6Src;
  logic [5:0]  r6Dst, r6Oe, r6Latch;
  logic [11:0] r6Bus, r6Word;

  int total = 0;
  int bad = 0;

  always #5 SYSCLK = ~SYSCLK;

  // Register file model: the enabled register drives its value onto the bus.
  always_comb begin
    case (oe)
      8'h01:   bus = 12'h111;
      8'h02:   bus = 12'h222;
      8'h04:   bus = 12'hABC;
      8'h08:   bus = 12'h333;
      8'h10:   bus = 12'h444;
      8'h20:   bus = 12'h555;
      8'h40:   bus = 12'h666;
      8'h80:   bus = 12'h777;
      default: bus = 12'h000;
    endcase
  end

  assign r6Bus = 12'h5A5;

  bus_xfer_seq #(.NREG(8), .W(12)) dut (
    .SYSCLK(SYSCLK), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst),
    .oe(oe), .hold(hold), .latch(latch), .done(done), .err(err),
    .bus(bus), .last_word(last_word)
  );

  bus_xfer_seq #(.NREG(6), .W(12)) dut6 (
    .SYSCLK(SYSCLK), .RESET_N(RESET_N),
    .req_valid(r6Valid), .req_ready(r6Ready),
    .req_src(r6Src), .req_dst(r6Dst),
    .oe(r6Oe), .hold(r6Hold), .latch(r6Latch), .done(r6Done), .err(r6Err),
    .bus(r6Bus), .last_word(r6Word)
  );

  typedef struct {
    logic        vld;
    logic [2:0]  src;
    logic [7:0]  dst;
    logic [7:0]  eOe;
    logic        eHold;
    logic [7:0]  eLatch;
    logic        eDone;
    logic        eErr;
    logic        busy;
    logic [11:0] eWord;
  } vec_t;

  vec_t tbl [13];

  bit          mon = 1'b0;
  int          cyc = 0;
  int          doneCyc [$];
  int          holdCyc [$];
  logic [7:0]  doneLatch [$];
  logic [7:0]  doneOe [$];

  always @(negedge SYSCLK) begin
    if (mon) begin
      cyc++;
      if (done) begin
        doneCyc.push_back(cyc);
        doneLatch.push_back(latch);
        doneOe.push_back(oe);
      end
      if (!hold) holdCyc.push_back(cyc);
    end
  end

  function automatic logic [31:0] pk(input logic rdy, input logic [7:0] o, input logic h,
                                     input logic [7:0] l, input logic d, input logic e,
                                     input logic [11:0] w);
    return {rdy, o, h, l, d, e, w};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] s, input logic [7:0] d);
    req_valid = v;
    req_src   = s;
    req_dst   = d;
  endtask

  task automatic step();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic sendReq(input logic [2:0] s, input logic [7:0] d);
    int wt;
    wt = 0;
    applyStimulus(1'b1, s, d);
    while (!req_ready && wt < 10) begin
      step();
      wt++;
    end
    if (wt >= 10) checkOutput("readyTimeout", {31'd0, req_ready}, 32'd1);
    step();
  endtask

  logic [31:0] actOut;
  logic [7:0]  expOe [3];
  logic [7:0]  expLat [3];

  initial begin
    tbl[0]  = '{1'b1, 3'd2, 8'h08, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[1]  = '{1'b0, 3'd0, 8'h00, 8'h04, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 12'h000};
    tbl[2]  = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h08, 1'b1, 1'b0, 1'b1, 12'hABC};
    tbl[3]  = '{1'b1, 3'd1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 12'hABC};
    tbl[4]  = '{1'b0, 3'd0, 8'h00, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 12'hABC};
    tbl[5]  = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 12'h222};
    tbl[6]  = '{1'b1, 3'd3, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 12'h222};
    tbl[7]  = '{1'b0, 3'd0, 8'h00, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 12'h222};
    tbl[8]  = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 12'h333};
    tbl[9]  = '{1'b1, 3'd0, 8'h01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 12'h333};
    tbl[10] = '{1'b0, 3'd0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 12'h333};
    tbl[11] = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 12'h111};
    tbl[12] = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 12'h111};

    applyStimulus(1'b0, 3'd0, 8'h00);
    r6Valid = 1'b0;
    r6Src   = 3'd0;
    r6Dst   = 6'h00;

    // Reset values while reset is held, then release between edges.
    #3;
    checkOutput("resetValues", pk(req_ready, oe, hold, latch, done, err, last_word),
                pk(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 12'h000));
    @(negedge SYSCLK);
    RESET_N = 1'b1;
    #1;
    checkOutput("readyBeforeFirstEdge", {31'd0, req_ready}, 32'd0);
    step();
    checkOutput("readyAfterFirstEdge", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].vld, tbl[i].src, tbl[i].dst);
      actOut = pk(req_ready, oe, hold, latch, done, err, last_word);
      checkOutput($sformatf("vec%0d", i), actOut,
                  pk(PIPE ? 1'b1 : !tbl[i].busy, tbl[i].eOe, tbl[i].eHold, tbl[i].eLatch,
                     tbl[i].eDone, tbl[i].eErr, tbl[i].eWord));
      step();
    end

    // Back-to-back requests: overlap when pipelined, 3-cycle spacing otherwise.
    mon = 1'b1;
    sendReq(3'd1, 8'h01);
    sendReq(3'd3, 8'h02);
    sendReq(3'd5, 8'h04);
    applyStimulus(1'b0, 3'd0, 8'h00);
    repeat (6) step();
    mon = 1'b0;
    expLat = '{8'h01, 8'h02, 8'h04};
    if (PIPE) expOe = '{8'h08, 8'h20, 8'h00};
    else      expOe = '{8'h00, 8'h00, 8'h00};
    checkOutput("b2bDoneCount", doneCyc.size(), 32'd3);
    checkOutput("b2bHoldLowCount", holdCyc.size(), 32'd3);
    if (doneCyc.size() == 3) begin
      checkOutput("b2bDoneGap1", doneCyc[1] - doneCyc[0], PIPE ? 32'd1 : 32'd3);
      checkOutput("b2bDoneGap2", doneCyc[2] - doneCyc[1], PIPE ? 32'd1 : 32'd3);
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("b2bLatch%0d", k), {24'd0, doneLatch[k]}, {24'd0, expLat[k]});
        checkOutput($sformatf("b2bOeAtDone%0d", k), {24'd0, doneOe[k]}, {24'd0, expOe[k]});
      end
    end
    if (holdCyc.size() == 3) begin
      checkOutput("b2bHoldSpan", holdCyc[2] - holdCyc[0], PIPE ? 32'd2 : 32'd6);
    end

    // Reset asserted with a LATCH pending: outputs clear at once, no strobe later.
    applyStimulus(1'b1, 3'd2, 8'h04);
    step();
    applyStimulus(1'b0, 3'd0, 8'h00);
    checkOutput("inflightDrive", {24'd0, oe}, 32'h04);
    #2;
    RESET_N = 1'b0;
    #1;
    checkOutput("asyncReset", pk(req_ready, oe, hold, latch, done, err, last_word),
                pk(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 12'h000));
    repeat (2) @(posedge SYSCLK);
    @(negedge SYSCLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("noLatchAfterReset%0d", i), {23'd0, latch, done}, 32'd0);
    end

    // Six-register instance: in-range source, then source 7 out of range.
    checkOutput("n6Ready", {31'd0, r6Ready}, 32'd1);
    r6Valid = 1'b1;
    r6Src   = 3'd5;
    r6Dst   = 6'h02;
    step();
    r6Valid = 1'b0;
    checkOutput("n6InRangeDrive", {24'd0, r6Oe, r6Hold, r6Err}, {24'd0, 6'h20, 1'b0, 1'b0});
    step();
    checkOutput("n6InRangeLatch", {17'd0, r6Latch, r6Done, r6Err, 6'd0},
                {17'd0, 6'h02, 1'b1, 1'b0, 6'd0});
    step();
    r6Valid = 1'b1;
    r6Src   = 3'd7;
    r6Dst   = 6'h01;
    step();
    r6Valid = 1'b0;
    checkOutput("n6BadSrcDrive", {24'd0, r6Oe, r6Hold, r6Err}, {24'd0, 6'h00, 1'b0, 1'b1});
    step();
    checkOutput("n6BadSrcLatch", {6'd0, r6Latch, r6Done, r6Err, r6Word},
                {6'd0, 6'h01, 1'b1, 1'b0, 12'h5A5});
    step();
    checkOutput("n6Idle", {29'd0, r6Done, r6Err, r6Hold}, {29'd0, 1'b0, 1'b0, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
